// File: rtl/button_debounce_irq_ctrl.sv
// Debounced 16-button input port with sticky edge capture and a maskable level IRQ.
// Each pin runs through its own synchroniser/debounce lane; the top holds the register file.

module button_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic bypass,
    output logic stable,
    output logic rise,
    output logic fall
);
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stable_nxt;

    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        if (bypass) begin
            stable_nxt = sync2;
        end else if (sync2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1))
                stable_nxt = sync2;
            else
                cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Edge events come from the next-state so capture lands on the same edge as stable.
    assign rise = stable_nxt & ~stable;
    assign fall = ~stable_nxt & stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
        end
    end
endmodule

module button_debounce_irq_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] stable, rise, fall;
    logic [WIDTH-1:0] edge_cap, irq_mask, cap_set, cap_clr;
    logic [2:0]       ctrl;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_wdata;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            button_debounce_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_lane (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (in_port[g]),
                .bypass (ctrl[2]),
                .stable (stable[g]),
                .rise   (rise[g]),
                .fall   (fall[g])
            );
        end
    endgenerate

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;
    assign cap_set      = (rise & {WIDTH{ctrl[0]}}) | (fall & {WIDTH{ctrl[1]}});
    assign cap_clr      = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: rd_mux[WIDTH-1:0] = irq_mask;
            2'd2: rd_mux[WIDTH-1:0] = edge_cap;
            default: rd_mux[2:0] = ctrl;
        endcase
    end

    // A new edge on the same cycle as a write-clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq_mask <= '0;
            ctrl     <= 3'b001;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
            if (wr && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 2'd3) ctrl <= writedata[2:0];
            readdata <= rd_mux;
            irq      <= |(edge_cap & irq_mask);
        end
    end
endmodule

// File: tb/tb_button_debounce_irq_ctrl.sv
// Directed bench for button_debounce_irq_ctrl with DEBOUNCE_CYCLES=4; read expectations go
// through a scoreboard queue and are compared when readdata comes back.

module tb_button_debounce_irq_ctrl;
    localparam int WIDTH = 16;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    button_debounce_irq_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Each task starts and ends at a negedge and spans exactly one posedge.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e = sb.pop_front();
        chk(e.tag, readdata, e.exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // 1: reset values
        rd(2'd0, 32'h0, "t1_data");
        rd(2'd1, 32'h0, "t1_mask");
        rd(2'd2, 32'h0, "t1_cap");
        rd(2'd3, 32'h1, "t1_ctrl");
        chk("t1_irq", {31'b0, irq}, 32'h0);

        // 2: bit0 rise; readdata after Ek shows stable after E(k-1), so 1 appears at k=7
        in_port = 16'h0001;
        for (int k = 1; k <= 8; k++)
            rd(2'd0, (k >= DEB + 3) ? 32'h1 : 32'h0, $sformatf("t2_data_e%0d", k));
        rd(2'd2, 32'h1, "t2_cap");
        chk("t2_irq_masked", {31'b0, irq}, 32'h0);

        // 3: mask, write-0 no-op, write-1 clear
        wr(2'd1, 32'h1);
        chk("t3_irq_lag", {31'b0, irq}, 32'h0);
        idle();
        chk("t3_irq_set", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h1, "t3_cap_w0");
        chk("t3_irq_still", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        chk("t3_irq_clr_lag", {31'b0, irq}, 32'h1);
        idle();
        chk("t3_irq_clr", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h0, "t3_cap_cleared");

        // 4: 3-cycle glitch on bit5 is rejected, 10-cycle pulse is accepted
        in_port = 16'h0021;
        for (int k = 1; k <= 3; k++) rd(2'd0, 32'h1, $sformatf("t4_glitch_e%0d", k));
        in_port = 16'h0001;
        for (int k = 4; k <= 10; k++) rd(2'd0, 32'h1, $sformatf("t4_glitch_e%0d", k));
        rd(2'd2, 32'h0, "t4_glitch_cap");
        in_port = 16'h0021;
        for (int k = 1; k <= 10; k++)
            rd(2'd0, (k >= DEB + 3) ? 32'h21 : 32'h1, $sformatf("t4_pulse_hi_e%0d", k));
        in_port = 16'h0001;
        for (int k = 1; k <= 8; k++)
            rd(2'd0, (k >= DEB + 3) ? 32'h1 : 32'h21, $sformatf("t4_pulse_lo_e%0d", k));
        rd(2'd2, 32'h20, "t4_pulse_cap");
        chk("t4_irq", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h20);

        // 5: falling-edge capture only
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h2, "t5_ctrl");
        in_port = 16'h0000;
        for (int k = 1; k <= 8; k++)
            rd(2'd2, (k >= DEB + 3) ? 32'h1 : 32'h0, $sformatf("t5_fall_cap_e%0d", k));
        chk("t5_irq_fall", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        in_port = 16'h0001;
        for (int k = 1; k <= 8; k++) rd(2'd2, 32'h0, $sformatf("t5_rise_cap_e%0d", k));
        rd(2'd0, 32'h1, "t5_rise_data");
        in_port = 16'h0000;
        repeat (DEB + 1) idle();
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "t5_set_wins");
        rd(2'd0, 32'h0, "t5_fall_data");

        // 6: bypass follows at E3, readdata at k=4
        wr(2'd2, 32'h1);
        wr(2'd3, 32'h5);
        in_port = 16'h8000;
        for (int k = 1; k <= 5; k++)
            rd(2'd0, (k >= 4) ? 32'h8000 : 32'h0, $sformatf("t6_byp_hi_e%0d", k));
        rd(2'd2, 32'h8000, "t6_byp_cap");
        in_port = 16'h0000;
        for (int k = 1; k <= 5; k++)
            rd(2'd0, (k >= 4) ? 32'h0 : 32'h8000, $sformatf("t6_byp_lo_e%0d", k));
        wr(2'd1, 32'h8000);
        wr(2'd3, 32'h1);
        idle();
        chk("t6_irq_pre", {31'b0, irq}, 32'h1);
        chk("t6_ctrl_pre", readdata, 32'h1);

        // reset mid-count in normal mode
        in_port = 16'h8000;
        repeat (4) idle();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_irq", {31'b0, irq}, 32'h0);
        chk("t6_rst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++)
            rd(2'd0, (k >= DEB + 3) ? 32'h8000 : 32'h0, $sformatf("t6_restart_e%0d", k));
        rd(2'd2, 32'h8000, "t6_powerup_cap");
        rd(2'd1, 32'h0, "t6_mask_rst");
        chk("t6_irq_end", {31'b0, irq}, 32'h0);
        chk("t6_sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_debounce_irq_ctrl.md
Name: button_debounce_irq_ctrl

Overview:
Avalon-MM slave controller for the 16-bit display-button input port. It synchronises and debounces each button and presents the stable state to the processor. It captures debounced edges into a sticky register and raises a maskable interrupt, replacing raw polling of the bare PIO input. It sits between the board button pins and the SoC interconnect/IRQ fabric.

Parameters:
WIDTH, 16, number of button inputs (1..32)
DEBOUNCE_CYCLES, 50000, cycles a changed input must stay stable before acceptance (>=2)
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, asynchronous, active-low
address  in  2  register word select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data, zero-extended above WIDTH
in_port  in  WIDTH  raw asynchronous button pins
irq  out  1  level interrupt, active-high

Behaviour:
- Register map (word addresses):
  - 0 DATA: debounced state, read-only; writes ignored.
  - 1 IRQ_MASK: RW; bit i enables button i.
  - 2 EDGE_CAP: read; a write of 1 clears that bit, 0 leaves it unchanged.
  - 3 CTRL: RW bits[2:0].
    - bit0 capture rising edges.
    - bit1 capture falling edges.
    - bit2 debounce bypass.
    - Other bits read 0.
- Reset values: readdata 0, irq 0, sync stages 0, stable 0, all counters 0, IRQ_MASK 0, EDGE_CAP 0, CTRL 3'b001.
- Synchroniser: two flops per bit (sync1, sync2). Debounce logic uses sync2 only.
- Debounce, per bit, on every clock edge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce latency: let E1 be the first edge that samples a new in_port level. stable changes at edge E(DEBOUNCE_CYCLES+2), provided the level is held.
- Glitch rejection: any return of sync2 to the stable value before the count completes clears cnt. No change is accepted.
- Bypass (CTRL bit2=1): stable <= sync2 every cycle, so stable changes at E3. Counters are held at 0. Toggling bypass mid-count clears the counters.
- Edge capture: on any cycle where stable[i] rises (and CTRL bit0=1) or falls (and CTRL bit1=1), EDGE_CAP[i] <= 1.
- Simultaneous set and write-clear on the same bit in the same cycle: set wins.
- irq = |(EDGE_CAP & IRQ_MASK[WIDTH-1:0]), driven from registers with no combinational path from bus inputs.
  - irq updates the cycle after the EDGE_CAP or IRQ_MASK change.
  - Masking a pending bit drops irq but leaves EDGE_CAP unchanged.
- Reads:
  - readdata is updated on every clock edge from address, whether or not chipselect is asserted. 1-cycle read latency, no wait states.
  - Reads have no side effects.
- Writes: take effect at the edge where chipselect=1 and write_n=0. Read-back of a written register reflects the new value 2 cycles after the write edge (write edge, then readdata register).
- Power-up with buttons held: stable starts at 0, so a held button produces a debounced rising edge DEBOUNCE_CYCLES+2 cycles after reset release. That edge is captured if CTRL bit0=1.
- Reset asserted mid-operation: all state returns to reset values immediately. Partial counts are discarded and irq deasserts asynchronously.
- WIDTH<32: upper readdata bits are 0, and upper writedata bits are ignored.

Test Plan:
(DEBOUNCE_CYCLES=4 for simulation)
1. Reset, then read all four addresses -> 0, 0, 0, 0x1. irq=0 throughout.
2. in_port 0x0000->0x0001, held -> DATA reads 0x0001, with stable changing exactly at E6. Then EDGE_CAP=0x0001. irq stays 0 while IRQ_MASK=0.
3. Write IRQ_MASK=0x0001 with a pending bit0 edge -> irq=1 the cycle after. Write EDGE_CAP=0x0001 -> EDGE_CAP=0 and irq=0 one cycle later. Writing 0x0000 leaves EDGE_CAP unchanged.
4. 3-cycle pulse on bit5 (0->1->0) -> DATA bit5 never sets, EDGE_CAP bit5 stays 0. A 10-cycle pulse sets and clears DATA bit5.
5. CTRL=0x2, release bit0 (1->0) -> EDGE_CAP bit0 set on the fall. A later rise sets nothing. Write-clear in the same cycle as a new fall -> bit remains 1.
6. CTRL=0x5 (bypass), toggle bit15 -> DATA follows at E3. Assert reset_n=0 mid-count in normal mode -> DATA=0, irq=0 immediately, count restarts from 0 after release.
